// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file access sequencer: command opcodes,
// FSM states and register-file geometry.
package regfile_seq_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_NULL = 0;

    typedef enum logic [1:0] {
        OP_LDI  = 2'd0,
        OP_MOV  = 2'd1,
        OP_SWAP = 2'd2,
        OP_CLR  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WR_A,
        WR_B,
        CLR
    } state_e;

endpackage

// File: rtl/regfile_seq.sv
// Register-file access sequencer: runs LDI/MOV/SWAP/CLR commands through the
// regfile's single write port and S-bus read port, one command at a time.
module regfile_seq
    import regfile_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [SEL_W-1:0]  cmd_dst,
    input  logic [SEL_W-1:0]  cmd_src,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rf_sbus_in,
    output logic [SEL_W-1:0]  rf_write_select,
    output logic [SEL_W-1:0]  rf_sbus_select,
    input  logic [DATA_W-1:0] rf_sbus_out
);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [SEL_W-1:0]    dst_q, dst_d;
    logic [SEL_W-1:0]    src_q, src_d;
    logic [SEL_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [DATA_W-1:0]   tmp_a_q, tmp_a_d;
    logic [DATA_W-1:0]   tmp_b_q, tmp_b_d;
    logic [SEL_W-1:0]    wsel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_LDI;
            dst_q   <= '0;
            src_q   <= '0;
            cnt_q   <= '0;
            imm_q   <= '0;
            tmp_a_q <= '0;
            tmp_b_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            imm_q   <= imm_d;
            tmp_a_q <= tmp_a_d;
            tmp_b_q <= tmp_b_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        dst_d          = dst_q;
        src_d          = src_q;
        cnt_d          = cnt_q;
        imm_d          = imm_q;
        tmp_a_d        = tmp_a_q;
        tmp_b_d        = tmp_b_q;
        cmd_ready      = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        wsel           = '0;
        rf_sbus_in     = '0;
        rf_sbus_select = '0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d  = op_e'(cmd_op);
                    dst_d = cmd_dst;
                    src_d = cmd_src;
                    imm_d = cmd_imm;
                    case (op_e'(cmd_op))
                        OP_LDI:  state_d = WR_A;
                        OP_MOV:  state_d = RD_A;
                        OP_SWAP: state_d = RD_A;
                        OP_CLR: begin
                            state_d = CLR;
                            cnt_d   = SEL_W'(1);
                        end
                    endcase
                end
            end
            // Register 0 reads as zero here regardless of what the S-bus returns.
            RD_A: begin
                busy           = 1'b1;
                rf_sbus_select = src_q;
                tmp_a_d        = (src_q == SEL_W'(REG_NULL)) ? '0 : rf_sbus_out;
                state_d        = (op_q == OP_SWAP) ? RD_B : WR_A;
            end
            RD_B: begin
                busy           = 1'b1;
                rf_sbus_select = dst_q;
                tmp_b_d        = (dst_q == SEL_W'(REG_NULL)) ? '0 : rf_sbus_out;
                state_d        = WR_A;
            end
            WR_A: begin
                busy       = 1'b1;
                wsel       = dst_q;
                rf_sbus_in = (op_q == OP_LDI) ? imm_q : tmp_a_q;
                if (op_q == OP_SWAP) begin
                    state_d = WR_B;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            WR_B: begin
                busy       = 1'b1;
                wsel       = src_q;
                rf_sbus_in = tmp_b_q;
                done       = 1'b1;
                state_d    = IDLE;
            end
            CLR: begin
                busy  = 1'b1;
                wsel  = cnt_q;
                cnt_d = cnt_q + SEL_W'(1);
                if (cnt_q == '1) begin
                    done    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A write state coinciding with reset must not commit at that edge.
    assign rf_write_select = rst_n ? wsel : '0;

endmodule

// File: tb/tb_regfile_seq.sv
// Directed self-checking bench for regfile_seq with a behavioural regfile
// attached to its write and S-bus ports.
module tb_regfile_seq;
    import regfile_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_dst;
    logic [4:0]  cmd_src;
    logic [31:0] cmd_imm;
    logic        busy;
    logic        done;
    logic [31:0] rf_sbus_in;
    logic [4:0]  rf_write_select;
    logic [4:0]  rf_sbus_select;
    logic [31:0] rf_sbus_out;

    logic [31:0] rf [32];

    int errors = 0;
    int checks = 0;

    regfile_seq #(.DATA_W(32), .SEL_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_dst         (cmd_dst),
        .cmd_src         (cmd_src),
        .cmd_imm         (cmd_imm),
        .busy            (busy),
        .done            (done),
        .rf_sbus_in      (rf_sbus_in),
        .rf_write_select (rf_write_select),
        .rf_sbus_select  (rf_sbus_select),
        .rf_sbus_out     (rf_sbus_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register 0 returns junk so the sequencer's own zeroing is exercised.
    always @(posedge clk) if (rf_write_select != 5'd0) rf[rf_write_select] <= rf_sbus_in;
    assign rf_sbus_out = (rf_sbus_select == 5'd0) ? 32'hBADC0DE5 : rf[rf_sbus_select];

    task automatic run_cmd(input logic [1:0] op, input logic [4:0] dst, input logic [4:0] src,
                           input logic [31:0] imm, output int nbusy, output int done_at,
                           output int nwr, output logic [4:0] wsel1, output logic [31:0] win1,
                           output logic [4:0] ssel1, output logic rdy_after);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
        @(negedge clk);
        cmd_valid = 1'b0;
        nbusy = 0; done_at = -1; nwr = 0;
        wsel1 = rf_write_select; win1 = rf_sbus_in; ssel1 = rf_sbus_select;
        for (int i = 0; i < 64; i++) begin
            if (!busy) break;
            nbusy++;
            if (done) done_at = nbusy;
            if (rf_write_select != 5'd0) nwr++;
            @(negedge clk);
        end
        rdy_after = cmd_ready;
    endtask

    task automatic load(input logic [4:0] r, input logic [31:0] v);
        int a, b, c; logic [4:0] d, f; logic [31:0] e; logic g;
        run_cmd(OP_LDI, r, 5'd0, v, a, b, c, d, e, f, g);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src = '0; cmd_imm = '0;
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        checks++; if (rf_write_select !== 5'd0) begin errors++; $display("FAIL rst_wsel: got %0d expected 0", rf_write_select); end
        checks++; if (rf_sbus_in !== 32'd0) begin errors++; $display("FAIL rst_sbus_in: got %h expected 0", rf_sbus_in); end
        checks++; if (rf_sbus_select !== 5'd0) begin errors++; $display("FAIL rst_ssel: got %0d expected 0", rf_sbus_select); end
        rst_n = 1'b1;
    endtask

    task automatic test_ldi;
        int nb, da, nw; logic [4:0] ws, ss; logic [31:0] wi; logic ra;
        run_cmd(OP_LDI, 5'd5, 5'd0, 32'hDEADBEEF, nb, da, nw, ws, wi, ss, ra);
        checks++; if (nb !== 1) begin errors++; $display("FAIL ldi_busy: got %0d expected 1", nb); end
        checks++; if (da !== 1) begin errors++; $display("FAIL ldi_done: got %0d expected 1", da); end
        checks++; if (ws !== 5'd5) begin errors++; $display("FAIL ldi_wsel: got %0d expected 5", ws); end
        checks++; if (wi !== 32'hDEADBEEF) begin errors++; $display("FAIL ldi_wdata: got %h expected deadbeef", wi); end
        checks++; if (ra !== 1'b1) begin errors++; $display("FAIL ldi_ready_after: got %b expected 1", ra); end
        checks++; if (rf[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL ldi_r5: got %h expected deadbeef", rf[5]); end
    endtask

    task automatic test_mov;
        int nb, da, nw; logic [4:0] ws, ss; logic [31:0] wi; logic ra;
        load(5'd3, 32'h12345678);
        run_cmd(OP_MOV, 5'd7, 5'd3, 32'h0, nb, da, nw, ws, wi, ss, ra);
        checks++; if (nb !== 2) begin errors++; $display("FAIL mov_busy: got %0d expected 2", nb); end
        checks++; if (da !== 2) begin errors++; $display("FAIL mov_done: got %0d expected 2", da); end
        checks++; if (nw !== 1) begin errors++; $display("FAIL mov_writes: got %0d expected 1", nw); end
        checks++; if (ss !== 5'd3) begin errors++; $display("FAIL mov_ssel: got %0d expected 3", ss); end
        checks++; if (ws !== 5'd0) begin errors++; $display("FAIL mov_rd_wsel: got %0d expected 0", ws); end
        checks++; if (rf[7] !== 32'h12345678) begin errors++; $display("FAIL mov_r7: got %h expected 12345678", rf[7]); end
        checks++; if (rf[3] !== 32'h12345678) begin errors++; $display("FAIL mov_r3: got %h expected 12345678", rf[3]); end
    endtask

    task automatic test_swap;
        int nb, da, nw; logic [4:0] ws, ss; logic [31:0] wi; logic ra;
        load(5'd1, 32'hAAAA0001);
        load(5'd2, 32'h5555_0002);
        run_cmd(OP_SWAP, 5'd2, 5'd1, 32'h0, nb, da, nw, ws, wi, ss, ra);
        checks++; if (nb !== 4) begin errors++; $display("FAIL swap_busy: got %0d expected 4", nb); end
        checks++; if (da !== 4) begin errors++; $display("FAIL swap_done: got %0d expected 4", da); end
        checks++; if (nw !== 2) begin errors++; $display("FAIL swap_writes: got %0d expected 2", nw); end
        checks++; if (rf[1] !== 32'h55550002) begin errors++; $display("FAIL swap_r1: got %h expected 55550002", rf[1]); end
        checks++; if (rf[2] !== 32'hAAAA0001) begin errors++; $display("FAIL swap_r2: got %h expected aaaa0001", rf[2]); end
        run_cmd(OP_SWAP, 5'd1, 5'd1, 32'h0, nb, da, nw, ws, wi, ss, ra);
        checks++; if (nb !== 4) begin errors++; $display("FAIL swap_same_busy: got %0d expected 4", nb); end
        checks++; if (rf[1] !== 32'h55550002) begin errors++; $display("FAIL swap_same_r1: got %h expected 55550002", rf[1]); end
    endtask

    task automatic test_clr;
        int nb, da, nw; logic [4:0] ws, ss; logic [31:0] wi; logic ra;
        for (int i = 1; i < 32; i++) load(5'(i), 32'hC0DE_0000 + 32'(i));
        run_cmd(OP_CLR, 5'd0, 5'd0, 32'h0, nb, da, nw, ws, wi, ss, ra);
        checks++; if (nb !== 31) begin errors++; $display("FAIL clr_busy: got %0d expected 31", nb); end
        checks++; if (da !== 31) begin errors++; $display("FAIL clr_done: got %0d expected 31", da); end
        checks++; if (nw !== 31) begin errors++; $display("FAIL clr_writes: got %0d expected 31", nw); end
        checks++; if (ws !== 5'd1) begin errors++; $display("FAIL clr_first_wsel: got %0d expected 1", ws); end
        checks++; if (ra !== 1'b1) begin errors++; $display("FAIL clr_ready_after: got %b expected 1", ra); end
        for (int i = 1; i < 32; i++) begin
            checks++;
            if (rf[i] !== 32'd0) begin errors++; $display("FAIL clr_r%0d: got %h expected 0", i, rf[i]); end
        end
    endtask

    task automatic test_reg0;
        int nb, da, nw; logic [4:0] ws, ss; logic [31:0] wi; logic ra;
        run_cmd(OP_LDI, 5'd0, 5'd0, 32'hFFFFFFFF, nb, da, nw, ws, wi, ss, ra);
        checks++; if (nw !== 0) begin errors++; $display("FAIL r0_ldi_writes: got %0d expected 0", nw); end
        checks++; if (nb !== 1) begin errors++; $display("FAIL r0_ldi_busy: got %0d expected 1", nb); end
        checks++; if (da !== 1) begin errors++; $display("FAIL r0_ldi_done: got %0d expected 1", da); end
        load(5'd4, 32'h44444444);
        run_cmd(OP_MOV, 5'd4, 5'd0, 32'h0, nb, da, nw, ws, wi, ss, ra);
        checks++; if (nb !== 2) begin errors++; $display("FAIL r0_mov_busy: got %0d expected 2", nb); end
        checks++; if (rf[4] !== 32'd0) begin errors++; $display("FAIL r0_mov_r4: got %h expected 0", rf[4]); end
    endtask

    task automatic test_reset_mid_swap;
        int nw;
        load(5'd1, 32'h11111111);
        load(5'd2, 32'h22222222);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_SWAP; cmd_dst = 5'd2; cmd_src = 5'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", cmd_ready); end
        checks++; if (rf_write_select !== 5'd0) begin errors++; $display("FAIL mid_rst_wsel: got %0d expected 0", rf_write_select); end
        checks++; if (rf_sbus_in !== 32'd0) begin errors++; $display("FAIL mid_rst_sbus_in: got %h expected 0", rf_sbus_in); end
        checks++; if (rf_sbus_select !== 5'd0) begin errors++; $display("FAIL mid_rst_ssel: got %0d expected 0", rf_sbus_select); end
        rst_n = 1'b1;
        nw = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rf_write_select != 5'd0) nw++;
        end
        checks++; if (nw !== 0) begin errors++; $display("FAIL mid_rst_writes: got %0d expected 0", nw); end
        checks++; if (rf[1] !== 32'h11111111) begin errors++; $display("FAIL mid_rst_r1: got %h expected 11111111", rf[1]); end
        checks++; if (rf[2] !== 32'h22222222) begin errors++; $display("FAIL mid_rst_r2: got %h expected 22222222", rf[2]); end
    endtask

    task automatic test_back_to_back;
        int nw, nd;
        nw = 0; nd = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_LDI; cmd_dst = 5'd6; cmd_src = 5'd0; cmd_imm = 32'h0BAD_F00D;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rf_write_select == 5'd6) nw++;
            if (done) nd++;
        end
        cmd_valid = 1'b0;
        checks++; if (nw !== 4) begin errors++; $display("FAIL b2b_writes: got %0d expected 4", nw); end
        checks++; if (nd !== 4) begin errors++; $display("FAIL b2b_dones: got %0d expected 4", nd); end
        checks++; if (rf[6] !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_r6: got %h expected 0badf00d", rf[6]); end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_mov();
        test_swap();
        test_clr();
        test_reg0();
        test_reset_mid_swap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
